// File: rtl/dmem_lsu.sv
`timescale 1ns/1ps
// dmem_lsu: byte-addressed, multi-cycle data memory for the MEM stage.
// Supports byte/half/word loads and stores, sign or zero extension on loads,
// alignment checking, WAIT wait states and a ready/done handshake.
// Optional feature: define DMEM_CLEAR_EN to zero the whole array in an INIT
// sweep (one word per cycle) after reset before the first request is taken.
module dmem_lsu #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        ReqIn,
  input  logic        WriteIn,
  input  logic [1:0]  SizeIn,
  input  logic        UnsignedIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] DataIn,
  output logic        ReadyOut,
  output logic        DoneOut,
  output logic [31:0] DataOut,
  output logic        MisalignOut
);

  localparam int IDXW = $clog2(DEPTH);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} state_t;
  localparam state_t RST_STATE = S_INIT;
  localparam logic   RST_READY = 1'b0;
`else
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_READY = 1'b1;
`endif

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            ready_q, done_q, mis_q;
  logic [31:0]     dout_q, dout_d;
`ifdef DMEM_CLEAR_EN
  logic [IDXW-1:0] init_idx_q;
`endif

  // Request fields, captured at the accept edge and held through the access.
  logic [31:0]     addr_q, wdata_q;
  logic            write_q, uns_q;
  logic [1:0]      size_q;

  logic [31:0]     mem_q [DEPTH];

  logic            misalign, in_range, exec;
  logic [IDXW-1:0] word_idx, mem_idx;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wd;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-justify the addressed lane(s) and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Decode the held request and drive the single array write port.
  always_comb begin
    misalign = is_misaligned(size_q, addr_q[1:0]);
    in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH));
    word_idx = addr_q[IDXW+1:2];
    exec     = (state_q == S_BUSY) && (cnt_q == 4'd0);
    dout_d   = (write_q || misalign || !in_range) ? 32'h0
             : load_extract(mem_q[word_idx], size_q, addr_q[1:0], uns_q);
    mem_we   = exec && write_q && !misalign && in_range;
    mem_idx  = word_idx;
    mem_be   = lane_mask(size_q, addr_q[1:0]);
    case (size_q)
      2'b00:   mem_wd = {4{wdata_q[7:0]}};
      2'b01:   mem_wd = {2{wdata_q[15:0]}};
      default: mem_wd = wdata_q;
    endcase
`ifdef DMEM_CLEAR_EN
    if (state_q == S_INIT) begin
      mem_we  = 1'b1;
      mem_idx = init_idx_q;
      mem_be  = 4'b1111;
      mem_wd  = 32'h0;
    end
`endif
  end

  // Byte-lane masked array write; the array itself is never reset.
  always_ff @(posedge clkIn) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_be[k]) mem_q[mem_idx][8*k +: 8] <= mem_wd[8*k +: 8];
      end
    end
  end

  // Capture the request fields when a request is accepted in IDLE.
  always_ff @(posedge clkIn) begin
    if (state_q == S_IDLE && ReqIn) begin
      addr_q  <= AddrIn;
      wdata_q <= DataIn;
      write_q <= WriteIn;
      size_q  <= SizeIn;
      uns_q   <= UnsignedIn;
    end
  end

  // Access sequencer with registered handshake and result outputs.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_q    <= RST_STATE;
      cnt_q      <= 4'd0;
      ready_q    <= RST_READY;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      dout_q     <= 32'h0;
`ifdef DMEM_CLEAR_EN
      init_idx_q <= '0;
`endif
    end else begin
      case (state_q)
`ifdef DMEM_CLEAR_EN
        S_INIT: begin
          if (init_idx_q == IDXW'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            init_idx_q <= init_idx_q + 1'b1;
          end
        end
`endif
        S_IDLE: begin
          if (ReqIn) begin
            state_q <= S_BUSY;
            cnt_q   <= 4'(WAIT);
            ready_q <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_RESP;
            done_q  <= 1'b1;
            mis_q   <= misalign;
            dout_q  <= dout_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReadyOut    = ready_q;
  assign DoneOut     = done_q;
  assign MisalignOut = mis_q;
  assign DataOut     = dout_q;

endmodule

// File: tb/tb_dmem_lsu.sv
`timescale 1ns/1ps
// Testbench for dmem_lsu: table of load/store vectors on a WAIT=2 instance,
// expected results queued at request time and popped at DoneOut, plus
// hand-written reset-abort and (optional) INIT-sweep sequences on a WAIT=3 instance.
module tb_dmem_lsu;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req3 = 1'b0;
  logic        wr = 1'b0, uns = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;

  logic        rdy, done, mis, rdy3, done3, mis3;
  logic [31:0] dout, dout3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
    logic        ne;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];

`ifdef DMEM_CLEAR_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(DEPTH), .WAIT(2)) u_dut (
    .clkIn(clk), .resetIn(rst), .ReqIn(req), .WriteIn(wr), .SizeIn(sz),
    .UnsignedIn(uns), .AddrIn(addr), .DataIn(wdata), .ReadyOut(rdy),
    .DoneOut(done), .DataOut(dout), .MisalignOut(mis)
  );

  dmem_lsu #(.DEPTH(DEPTH), .WAIT(3)) u_dut3 (
    .clkIn(clk), .resetIn(rst), .ReqIn(req3), .WriteIn(wr), .SizeIn(sz),
    .UnsignedIn(uns), .AddrIn(addr), .DataIn(wdata), .ReadyOut(rdy3),
    .DoneOut(done3), .DataOut(dout3), .MisalignOut(mis3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, want);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] e, input logic m);
    vec_t v;
    v.wr = w; v.sz = s; v.uns = u; v.addr = a; v.wdata = d; v.exp = e; v.mis = m;
    return v;
  endfunction

  // One complete transaction on instance sel (0: WAIT=2, 1: WAIT=3).
  task automatic do_req(input bit sel, input vec_t v, input logic ne, input string nm);
    int          n;
    int          lat;
    logic        rdy_low;
    logic [31:0] held;
    exp_t        e;
    e.d = v.exp; e.m = v.mis; e.ne = ne;
    sbq.push_back(e);
    n = 0;
    while (!(sel ? rdy3 : rdy) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " ready"}, 32'(sel ? rdy3 : rdy), 32'd1);
    wr = v.wr; sz = v.sz; uns = v.uns; addr = v.addr; wdata = v.wdata;
    if (sel) req3 = 1'b1; else req = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the block must ignore them until it is idle again.
    req = 1'b0; req3 = 1'b0;
    wr = ~v.wr; sz = ~v.sz; uns = ~v.uns; addr = ~v.addr; wdata = ~v.wdata;
    lat = 1;
    rdy_low = 1'b1;
    while (!(sel ? done3 : done) && lat < 40) begin
      if (sel ? rdy3 : rdy) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (sel ? rdy3 : rdy) rdy_low = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'(sel ? 5 : 4));
    chk({nm, " ready low while busy"}, 32'(rdy_low), 32'd1);
    e = sbq.pop_front();
    held = sel ? dout3 : dout;
    if (e.ne) begin
      checks++;
      if (held === e.d) begin
        errors++;
        $display("FAIL %s data: actual=%h required anything but %h", nm, held, e.d);
      end
    end else begin
      chk({nm, " data"}, held, e.d);
    end
    chk({nm, " misalign"}, 32'(sel ? mis3 : mis), 32'(e.m));
    @(posedge clk); #1;
    chk({nm, " done one cycle"}, 32'(sel ? done3 : done), 32'd0);
    chk({nm, " ready after done"}, 32'(sel ? rdy3 : rdy), 32'd1);
    chk({nm, " data held"}, sel ? dout3 : dout, held);
  endtask

  initial begin
    int   n;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(rdy), 32'(RST_READY));
    chk("reset done", 32'(done), 32'd0);
    chk("reset misalign", 32'(mis), 32'd0);
    chk("reset data", dout, 32'h0);
    rst = 1'b0;

`ifdef DMEM_CLEAR_EN
    // Request held high through the sweep must not be taken.
    wr = 1'b1; sz = 2'b10; addr = 32'h0; wdata = 32'hFFFF_FFFF; req = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!rdy && n < 1000) begin
      @(posedge clk); #1; n++;
      seen |= done;
    end
    req = 1'b0;
    chk("init ready-low cycles", 32'(n), 32'(DEPTH));
    chk("init no done", 32'(seen), 32'd0);
    do_req(0, mk(0, 2'b10, 0, 32'h0000_0000, 32'h0, 32'h0, 0), 0, "init load 0x000");
    do_req(0, mk(0, 2'b10, 0, 32'h0000_03FC, 32'h0, 32'h0, 0), 0, "init load 0x3FC");
    do_req(0, mk(0, 2'b10, 0, 32'h0000_0200, 32'h0, 32'h0, 0), 0, "init load 0x200");
`endif

    // wr, size, uns, addr, store data, expected DataOut, expected MisalignOut
    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEAD_BEEF, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h12,  32'hAAAA_AA7F, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13,  32'h0,         32'hFFFF_FFDE, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,         32'hDE7F_BEEF, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h12,  32'h0,         32'h0000_DE7F, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h10,  32'h0,         32'hFFFF_BEEF, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h11,  32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 2'b01, 0, 32'h13,  32'h0000_1111, 32'h0,         1));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10,  32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 2'b11, 0, 32'h10,  32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,         32'hDE7F_BEEF, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0,   32'h0123_4567, 32'h0,         0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h400, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0,   32'h0,         32'h0123_4567, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h11,  32'h0,         32'h0000_00BE, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h11,  32'h0,         32'hFFFF_FFBE, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h16,  32'hABCD_8001, 32'h0,         0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h16,  32'h0,         32'hFFFF_8001, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h16,  32'h0,         32'h0000_8001, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h12,  32'h0,         32'h0000_007F, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10,  32'h0,         32'hFFFF_FFEF, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,         32'hFFFF_DE7F, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10,  32'h0,         32'h0000_BEEF, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h12,  32'h0,         32'h0000_007F, 0));

    foreach (vecs[i]) do_req(0, vecs[i], 0, $sformatf("v%0d", i));

    // Reset one cycle after a WAIT=3 store is accepted: aborted, not committed.
    n = 0;
    while (!rdy3 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    wr = 1'b1; sz = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h1234_5678; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort reset done", 32'(done3), 32'd0);
    chk("abort reset ready", 32'(rdy3), 32'(RST_READY));
    chk("abort reset misalign", 32'(mis3), 32'd0);
    chk("reset clears held data", dout, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= done3;
    end
    chk("abort no done", 32'(seen), 32'd0);
`ifdef DMEM_CLEAR_EN
    do_req(1, mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0), 0, "abort load 0x20");
`else
    do_req(1, mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h1234_5678, 0), 1, "abort load 0x20");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
